// File: rtl/array2rwp_clr.sv
// array2rwp_clr: single-clock true dual-port RAM with write-first forwarding,
// a parametrised output pipeline, same-address write collision flag and a
// clear sequencer that fills the array with INITVAL after reset or on request.
module array2rwp_clr #(
  parameter int unsigned      ADDRBIT = 6,
  parameter int unsigned      DEPTH   = 48,
  parameter int unsigned      WIDTH   = 80,
  parameter int unsigned      PIPE    = 1,
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [ADDRBIT-1:0] a0,
  input  logic [ADDRBIT-1:0] a1,
  input  logic               we0,
  input  logic               we1,
  input  logic               re0,
  input  logic               re1,
  input  logic [WIDTH-1:0]   di0,
  input  logic [WIDTH-1:0]   di1,
  output logic [WIDTH-1:0]   do0,
  output logic [WIDTH-1:0]   do1,
  output logic               vld0,
  output logic               vld1,
  input  logic               clr,
  output logic               busy,
  output logic               colerr
);

  // One extra address bit so DEPTH itself is representable for range checks.
  localparam logic [ADDRBIT:0]   DepthExt = (ADDRBIT + 1)'(DEPTH);
  localparam logic [ADDRBIT-1:0] LastAddr = ADDRBIT'(DEPTH - 1);

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StIdle  = 1'b1
  } state_e;

  state_e             r_state;
  logic [ADDRBIT-1:0] r_cnt;
  logic               r_busy;
  logic               r_colerr;

  logic [WIDTH-1:0]   r_mem [DEPTH];

  // Read pipeline: stage 0 is the array read stage, stages 1..PIPE are extra.
  logic [WIDTH-1:0]   r_pd [2][PIPE+1];
  logic [PIPE:0]      r_pv [2];

  logic               w_idle;
  logic [ADDRBIT-1:0] w_addr [2];
  logic [1:0]         w_inr;
  logic [1:0]         w_re;
  logic               w_wr0;
  logic               w_wr1;
  logic               w_col;
  logic [1:0]         w_rd_en;
  logic [WIDTH-1:0]   w_rd_data [2];

  assign w_idle    = (r_state == StIdle);
  assign w_addr[0] = a0;
  assign w_addr[1] = a1;
  assign w_re      = {re1, re0};

  // Address range checks and accepted write strobes; port 0 wins a collision.
  always_comb begin
    w_inr[0] = ({1'b0, a0} < DepthExt);
    w_inr[1] = ({1'b0, a1} < DepthExt);
    w_col    = w_idle & we0 & we1 & w_inr[0] & (a0 == a1);
    w_wr0    = w_idle & we0 & w_inr[0];
    w_wr1    = w_idle & we1 & w_inr[1] & ~w_col;
  end

  // Write-first read data: forward this cycle's writes ahead of the array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_en[p]   = w_idle & w_re[p];
      w_rd_data[p] = INITVAL;
      if (!w_inr[p]) begin
        w_rd_data[p] = INITVAL;
      end else if (w_wr0 && (a0 == w_addr[p])) begin
        w_rd_data[p] = di0;
      end else if (w_wr1 && (a1 == w_addr[p])) begin
        w_rd_data[p] = di1;
      end else begin
        w_rd_data[p] = r_mem[w_addr[p]];
      end
    end
  end

  // Clear/idle sequencer with registered busy flag.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= StClear;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        StClear: begin
          if (r_cnt == LastAddr) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + ADDRBIT'(1);
          end
        end
        StIdle: begin
          if (clr) begin
            r_state <= StClear;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= StClear;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Array writes; port 1 is applied first so port 0 overrides on a collision.
  always_ff @(posedge clk) begin
    if (r_state == StClear) begin
      r_mem[r_cnt] <= INITVAL;
    end else begin
      if (w_wr1) begin
        r_mem[a1] <= di1;
      end
      if (w_wr0) begin
        r_mem[a0] <= di0;
      end
    end
  end

  // Collision flag, high for the single cycle after the colliding edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_colerr <= 1'b0;
    end else begin
      r_colerr <= w_col;
    end
  end

  // Read pipeline; data stages only load on valid so outputs hold otherwise.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int p = 0; p < 2; p++) begin
        r_pv[p] <= '0;
        for (int i = 0; i <= PIPE; i++) begin
          r_pd[p][i] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_pv[p][0] <= w_rd_en[p];
        if (w_rd_en[p]) begin
          r_pd[p][0] <= w_rd_data[p];
        end
        for (int i = 1; i <= PIPE; i++) begin
          r_pv[p][i] <= r_pv[p][i-1];
          if (r_pv[p][i-1]) begin
            r_pd[p][i] <= r_pd[p][i-1];
          end
        end
      end
    end
  end

  assign do0    = r_pd[0][PIPE];
  assign do1    = r_pd[1][PIPE];
  assign vld0   = r_pv[0][PIPE];
  assign vld1   = r_pv[1][PIPE];
  assign busy   = r_busy;
  assign colerr = r_colerr;

endmodule
